// File: rtl/cache_stream_fifo.sv
// cache_stream_fifo
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on
// both sides. Supports any depth >= 2 (including non-power-of-2) through
// explicit index wrap and a separate occupancy counter. Provides run-time
// almost-full / almost-empty thresholds and a clearable high-water mark.
module cache_stream_fifo #(
   parameter  int DATA_WIDTH = 32,
   parameter  int FIFO_DEPTH = 16,
   localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  soft_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  count,
   input  logic [CNT_WIDTH-1:0]  af_thresh,
   input  logic [CNT_WIDTH-1:0]  ae_thresh,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_WIDTH-1:0]  hwm,
   input  logic                  hwm_clr
);

   localparam int                   IDX_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(FIFO_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [IDX_WIDTH-1:0]  wr_idx;
   logic [IDX_WIDTH-1:0]  rd_idx;
   logic [CNT_WIDTH-1:0]  count_next;
   logic [CNT_WIDTH-1:0]  hwm_next;
   logic                  full;
   logic                  empty;
   logic                  wr_fire;
   logic                  rd_fire;
   logic                  wr_en;
   logic                  rd_en;

   // Advance an index by one, wrapping at the last entry rather than at a
   // power of two so that odd depths use exactly FIFO_DEPTH slots.
   function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   // Handshake flags come from the occupancy register only, never from a
   // pointer compare; in_ready deliberately ignores out_ready.
   always_comb begin
      full      = (count == DEPTH_CNT);
      empty     = (count == '0);
      in_ready  = ~full;
      out_valid = ~empty;
      wr_fire   = in_valid & in_ready;
      rd_fire   = out_valid & out_ready;
      // A flush cycle discards both transfers, so state only moves on *_en.
      wr_en     = wr_fire & ~soft_rst;
      rd_en     = rd_fire & ~soft_rst;
   end

   // Next occupancy and next high-water mark.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // through the block leaves it unassigned and infers a latch.
      count_next = count;
      hwm_next   = hwm;
      case ({wr_en, rd_en})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
      if (soft_rst) begin
         hwm_next = '0;
      end else if (hwm_clr) begin
         hwm_next = count_next;
      end else if (count_next > hwm) begin
         hwm_next = count_next;
      end
   end

   // Index, occupancy and high-water-mark registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
         hwm    <= '0;
      end else if (soft_rst) begin
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= '0;
         hwm    <= '0;
      end else begin
         if (wr_en) wr_idx <= next_idx(wr_idx);
         if (rd_en) rd_idx <= next_idx(rd_idx);
         count <= count_next;
         hwm   <= hwm_next;
      end
   end

   // Storage array: cleared on power-on reset, left intact by soft_rst.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the array is reset so out_data reads 0 out of reset; this
      // forces flops rather than RAM, acceptable for a small stream buffer.
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= in_data;
      end
   end

   // Head entry falls through straight from the array; no write bypass.
   always_comb begin
      out_data     = mem[rd_idx];
      almost_full  = (count >= af_thresh);
      almost_empty = (count <= ae_thresh);
   end

`ifdef DEBUG
   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
      count <= DEPTH_CNT);

   a_idx_bound : assert property (@(posedge clk) disable iff (!rst_n)
      (int'(wr_idx) < FIFO_DEPTH) && (int'(rd_idx) < FIFO_DEPTH));

   a_head_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !soft_rst) |=> ($stable(out_data) && out_valid));
`endif

endmodule

// File: tb/tb_cache_stream_fifo.sv
// Directed testbench for cache_stream_fifo at FIFO_DEPTH=5, DATA_WIDTH=8.
module tb_cache_stream_fifo;

   localparam int DW = 8;
   localparam int DEPTH = 5;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          soft_rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] count;
   logic [CW-1:0] af_thresh;
   logic [CW-1:0] ae_thresh;
   logic          almost_full;
   logic          almost_empty;
   logic [CW-1:0] hwm;
   logic          hwm_clr;

   int n_checks = 0;
   int n_pass   = 0;

   cache_stream_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .hwm(hwm), .hwm_clr(hwm_clr)
   );

   always #5 clk = ~clk;

   // Advance one clock; results are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; soft_rst = 1'b0; hwm_clr = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      af_thresh = 3'd0; ae_thresh = 3'd1;
      #3;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else n_pass++;
      n_checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (hwm !== 3'd0) $display("FAIL reset_hwm: got %0d want 0", hwm); else n_pass++;
      n_checks++; if (almost_full !== 1'b1) $display("FAIL reset_af_zero_thresh: got %b want 1", almost_full); else n_pass++;
      n_checks++; if (almost_empty !== 1'b1) $display("FAIL reset_ae: got %b want 1", almost_empty); else n_pass++;
      tick();
      rst_n = 1'b1;
      af_thresh = 3'd4;
      tick();
   endtask

   // Fill 0x11..0x55 with the consumer stalled, then try a 6th push.
   task automatic test_fill();
      logic [4:0] exp_af;
      logic [4:0] exp_ae;
      exp_af = 5'b11000;  // bit k = expected almost_full at count k+1
      exp_ae = 5'b00001;  // bit k = expected almost_empty at count k+1
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         in_data = 8'((i + 1) * 8'h11);
         n_checks++; if (in_ready !== 1'b1) $display("FAIL fill_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
         tick();
         n_checks++; if (count !== 3'(i + 1)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); else n_pass++;
         n_checks++; if (almost_full !== exp_af[i]) $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, exp_af[i]); else n_pass++;
         n_checks++; if (almost_empty !== exp_ae[i]) $display("FAIL fill_ae[%0d]: got %b want %b", i, almost_empty, exp_ae[i]); else n_pass++;
      end
      n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", in_ready); else n_pass++;
      in_data = 8'h66;
      tick();
      n_checks++; if (count !== 3'd5) $display("FAIL overflow_count: got %0d want 5", count); else n_pass++;
      n_checks++; if (out_data !== 8'h11) $display("FAIL overflow_head: got %h want 11", out_data); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL overflow_in_ready: got %b want 0", in_ready); else n_pass++;
      in_valid = 1'b0;
   endtask

   // Drain with out_ready held high: one word per cycle, in order.
   task automatic test_drain();
      logic [4:0] exp_af;
      logic [4:0] exp_ae;
      exp_af = 5'b00011;  // bit i = expected almost_full at count 5-i
      exp_ae = 5'b10000;  // bit i = expected almost_empty at count 5-i
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++; if (out_valid !== 1'b1) $display("FAIL drain_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
         n_checks++; if (out_data !== 8'((i + 1) * 8'h11)) $display("FAIL drain_data[%0d]: got %h want %h", i, out_data, 8'((i + 1) * 8'h11)); else n_pass++;
         n_checks++; if (almost_full !== exp_af[i]) $display("FAIL drain_af[%0d]: got %b want %b", i, almost_full, exp_af[i]); else n_pass++;
         n_checks++; if (almost_empty !== exp_ae[i]) $display("FAIL drain_ae[%0d]: got %b want %b", i, almost_empty, exp_ae[i]); else n_pass++;
         tick();
      end
      n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_end_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (count !== 3'd0) $display("FAIL drain_end_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (hwm !== 3'd5) $display("FAIL drain_end_hwm: got %0d want 5", hwm); else n_pass++;
      n_checks++; if (almost_empty !== 1'b1) $display("FAIL drain_end_ae: got %b want 1", almost_empty); else n_pass++;
      out_ready = 1'b0;
   endtask

   // 23 cycles of simultaneous push/pop, data = cycle number; indices wrap.
   task automatic test_back_to_back();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 8'd0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_no_bypass: got %b want 0", out_valid); else n_pass++;
      tick();
      for (int c = 1; c < 23; c++) begin
         in_data = 8'(c);
         n_checks++; if (out_data !== 8'(c - 1) || out_valid !== 1'b1) $display("FAIL stream_data[%0d]: got %h/%b want %h/1", c, out_data, out_valid, 8'(c - 1)); else n_pass++;
         tick();
         n_checks++; if (count !== 3'd1) $display("FAIL stream_count[%0d]: got %0d want 1", c, count); else n_pass++;
      end
      in_valid = 1'b0;
      n_checks++; if (out_data !== 8'd22) $display("FAIL stream_last: got %h want 16", out_data); else n_pass++;
      tick();
      n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL stream_empty: got %0d/%b want 0/0", count, out_valid); else n_pass++;
      n_checks++; if (hwm !== 3'd5) $display("FAIL stream_hwm: got %0d want 5", hwm); else n_pass++;
      out_ready = 1'b0;
   endtask

   // soft_rst coinciding with a push and a pop at count=3.
   task automatic test_soft_rst();
      in_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_data = 8'(i);
         tick();
      end
      n_checks++; if (count !== 3'd3) $display("FAIL srst_pre_count: got %0d want 3", count); else n_pass++;
      in_data   = 8'h77;
      out_ready = 1'b1;
      soft_rst  = 1'b1;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) $display("FAIL srst_handshake: got %b/%b want 1/1", in_ready, out_valid); else n_pass++;
      tick();
      soft_rst  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_checks++; if (count !== 3'd0) $display("FAIL srst_count: got %0d want 0", count); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL srst_valid: got %b want 0", out_valid); else n_pass++;
      n_checks++; if (hwm !== 3'd0) $display("FAIL srst_hwm: got %0d want 0", hwm); else n_pass++;
      in_valid = 1'b1;
      in_data  = 8'hA5;
      tick();
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) $display("FAIL srst_next_write: got %h/%b want a5/1", out_data, out_valid); else n_pass++;
      n_checks++; if (count !== 3'd1 || hwm !== 3'd1) $display("FAIL srst_next_count: got %0d/%0d want 1/1", count, hwm); else n_pass++;
   endtask

   // hwm_clr loads the current occupancy, then tracks further growth.
   task automatic test_hwm();
      in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = 8'(8'hB0 + i);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      out_ready = 1'b0;
      n_checks++; if (count !== 3'd2 || hwm !== 3'd5) $display("FAIL hwm_pre: got %0d/%0d want 2/5", count, hwm); else n_pass++;
      n_checks++; if (out_data !== 8'hB3) $display("FAIL hwm_head: got %h want b3", out_data); else n_pass++;
      hwm_clr = 1'b1;
      tick();
      hwm_clr = 1'b0;
      n_checks++; if (hwm !== 3'd2) $display("FAIL hwm_clr: got %0d want 2", hwm); else n_pass++;
      in_valid = 1'b1;
      in_data  = 8'hC1;
      tick();
      in_valid = 1'b0;
      n_checks++; if (hwm !== 3'd3 || count !== 3'd3) $display("FAIL hwm_grow: got %0d/%0d want 3/3", hwm, count); else n_pass++;
   endtask

   // Asynchronous reset asserted between clock edges during a transfer.
   task automatic test_async_reset();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 8'hD1;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0 || hwm !== 3'd0) $display("FAIL arst_count_hwm: got %0d/%0d want 0/0", count, hwm); else n_pass++;
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL arst_handshake: got %b/%b want 1/0", in_ready, out_valid); else n_pass++;
      n_checks++; if (out_data !== 8'h00) $display("FAIL arst_out_data: got %h want 00", out_data); else n_pass++;
      n_checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) $display("FAIL arst_flags: got %b/%b want 0/1", almost_full, almost_empty); else n_pass++;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL arst_release: got %0d/%b want 0/0", count, out_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_soft_rst();
      test_hwm();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
